// File: rtl/mna_resp_pkg.sv
// Shared constants for the NoC-to-AXI4-Lite response driver: flit layout,
// flit-type codes and FSM state encoding.
package mna_resp_pkg;

    localparam int unsigned FLIT_W = 37;
    localparam int unsigned DATA_W = 32;

    // Flit type lives in the two most significant flit bits
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] PAYLOAD = 2'b01;
    localparam logic [1:0] HDR     = 2'b10;
    localparam logic [1:0] RSVD    = 2'b11;

    localparam int unsigned HDR_WRITE_BIT = 0;
    localparam int unsigned HDR_RESP_LSB  = 1;
    localparam int unsigned HDR_RESP_W    = 2;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StWaitData = 2'b01,
        StSendB    = 2'b10,
        StSendR    = 2'b11
    } state_e;

endpackage

// File: rtl/mna_resp_axi_driver.sv
// Turns NoC response flits into AXI4-Lite B/R channel beats, one outstanding response.
// Optional MNA_RESP_ERR_CHECK_EN makes err_proto a sticky flag for dropped flits.
module mna_resp_axi_driver
    import mna_resp_pkg::*;
#(
    parameter int unsigned FLIT_W = mna_resp_pkg::FLIT_W,
    parameter int unsigned DATA_W = mna_resp_pkg::DATA_W
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [FLIT_W-1:0] noc_data,
    input  logic              noc_valid,
    output logic              noc_ready,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              err_proto
);

`ifdef MNA_RESP_ERR_CHECK_EN
    localparam bit ErrCheckEn = 1'b1;
`else
    localparam bit ErrCheckEn = 1'b0;
`endif

    localparam int unsigned TypeLsb = FLIT_W - 2;

    state_e                  state_q, state_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    accept;
    logic                    drop;
    logic [1:0]              flit_type;
    logic                    hdr_write;
    logic [HDR_RESP_W-1:0]   hdr_resp;
    logic                    unused_flit;

    assign flit_type   = noc_data[FLIT_W-1:TypeLsb];
    assign hdr_write   = noc_data[HDR_WRITE_BIT];
    assign hdr_resp    = noc_data[HDR_RESP_LSB +: HDR_RESP_W];
    assign unused_flit = ^noc_data[FLIT_W-3:DATA_W];

    assign noc_ready = (state_q == StIdle) || (state_q == StWaitData);
    assign accept    = noc_valid && noc_ready;

    always_comb begin
        state_d = state_q;
        bresp_d = bresp_q;
        rresp_d = rresp_q;
        rdata_d = rdata_q;
        drop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (flit_type == HDR) begin
                        if (hdr_write) begin
                            bresp_d = hdr_resp;
                            state_d = StSendB;
                        end else begin
                            rresp_d = hdr_resp;
                            state_d = StWaitData;
                        end
                    end else if (flit_type == PAYLOAD || flit_type == RSVD) begin
                        drop = 1'b1;
                    end
                end
            end
            StWaitData: begin
                if (accept) begin
                    if (flit_type == PAYLOAD) begin
                        rdata_d = noc_data[DATA_W-1:0];
                        state_d = StSendR;
                    end else if (flit_type == HDR || flit_type == RSVD) begin
                        drop = 1'b1;
                    end
                end
            end
            StSendB: begin
                if (bready) begin
                    state_d = StIdle;
                end
            end
            StSendR: begin
                if (rready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // With checking disabled err_q never leaves its reset value of 0
        err_d = err_q | (ErrCheckEn & drop);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
            bresp_q <= '0;
            rresp_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bvalid    = (state_q == StSendB);
    assign rvalid    = (state_q == StSendR);
    assign bresp     = bresp_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign err_proto = err_q;

endmodule

// File: tb/tb_mna_resp_axi_driver.sv
// Directed bench for mna_resp_axi_driver: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every B/R handshake.
module tb_mna_resp_axi_driver;
    import mna_resp_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [36:0] noc_data;
    logic        noc_valid;
    logic        noc_ready;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        err_proto;

`ifdef MNA_RESP_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct packed {
        logic        is_write;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 ACLK = ~ACLK;

    mna_resp_axi_driver dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .noc_data  (noc_data),
        .noc_valid (noc_valid),
        .noc_ready (noc_ready),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .err_proto (err_proto)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepts the flit
    task automatic drive_flit(input logic [36:0] f);
        noc_data  = f;
        noc_valid = 1'b1;
        @(posedge ACLK);
        #1;
        noc_valid = 1'b0;
        noc_data  = '0;
    endtask

    task automatic next_cycle();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bvalid"}, bvalid, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_bresp"}, bresp, 0);
        check({tag, "_rresp"}, rresp, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_err"}, err_proto, 0);
        check({tag, "_noc_ready"}, noc_ready, 1);
    endtask

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (bvalid && bready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got bresp %0h expected no response", bresp);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("b_kind", 1, mon_e.is_write);
                    check("bresp", bresp, mon_e.resp);
                end
            end
            if (rvalid && rready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got rdata %0h expected no response", rdata);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("r_kind", 0, mon_e.is_write);
                    check("rresp", rresp, mon_e.resp);
                    check("rdata", rdata, mon_e.data);
                end
            end
        end
    end

    initial begin
        ARESET    = 1'b1;
        noc_valid = 1'b0;
        noc_data  = '0;
        bready    = 1'b0;
        rready    = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check_all_zero("reset");
        ARESET = 1'b0;
        next_cycle();
        check("post_reset_noc_ready", noc_ready, 1);

        // Write response, ready already high
        bready = 1'b1;
        sb_q.push_back('{1'b1, 2'b00, 32'h0});
        drive_flit(37'h10_0000_0001);
        check("wr_bvalid", bvalid, 1);
        check("wr_bresp", bresp, 2'b00);
        check("wr_noc_ready", noc_ready, 0);
        next_cycle();
        check("wr_done_bvalid", bvalid, 0);
        check("wr_done_noc_ready", noc_ready, 1);

        // Read response with an idle flit between header and payload
        rready = 1'b1;
        sb_q.push_back('{1'b0, 2'b10, 32'hDEAD_BEEF});
        drive_flit(37'h10_0000_0004);
        check("rd_hdr_rvalid", rvalid, 0);
        check("rd_hdr_noc_ready", noc_ready, 1);
        check("rd_hdr_rresp", rresp, 2'b10);
        drive_flit(37'h00_0000_0000);
        check("rd_idle_rvalid", rvalid, 0);
        check("rd_idle_noc_ready", noc_ready, 1);
        drive_flit(37'h08_DEAD_BEEF);
        check("rd_rvalid", rvalid, 1);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_noc_ready", noc_ready, 0);
        next_cycle();
        check("rd_done_rvalid", rvalid, 0);

        // Write backpressure; an offered flit must not be taken while holding
        bready = 1'b0;
        sb_q.push_back('{1'b1, 2'b11, 32'h0});
        drive_flit(37'h10_0000_0007);
        noc_data  = 37'h10_0000_0001;
        noc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", bvalid, 1);
            check("bp_bresp", bresp, 2'b11);
            check("bp_noc_ready", noc_ready, 0);
            next_cycle();
        end
        bready    = 1'b1;
        noc_valid = 1'b0;
        noc_data  = '0;
        next_cycle();
        check("bp_done_bvalid", bvalid, 0);
        next_cycle();
        check("bp_no_second_b", bvalid, 0);

        // Read backpressure
        rready = 1'b0;
        sb_q.push_back('{1'b0, 2'b01, 32'h1234_5678});
        drive_flit(37'h10_0000_0002);
        drive_flit(37'h08_1234_5678);
        check("rbp_rvalid", rvalid, 1);
        next_cycle();
        check("rbp_rvalid_hold", rvalid, 1);
        check("rbp_rdata_hold", rdata, 32'h1234_5678);
        check("rbp_rresp_hold", rresp, 2'b01);
        rready = 1'b1;
        next_cycle();
        check("rbp_done_rvalid", rvalid, 0);

        // Protocol errors: payload and reserved in IDLE, header in WAIT_DATA
        check("err_before", err_proto, 0);
        drive_flit(37'h08_1111_1111);
        check("pe_idle_rvalid", rvalid, 0);
        check("pe_idle_bvalid", bvalid, 0);
        check("pe_idle_rdata", rdata, 32'h1234_5678);
        check("pe_err", err_proto, EXP_ERR);
        drive_flit(37'h18_0000_0000);
        check("pe_rsvd_noc_ready", noc_ready, 1);
        sb_q.push_back('{1'b0, 2'b01, 32'hCAFE_F00D});
        drive_flit(37'h10_0000_0002);
        drive_flit(37'h10_0000_0001);
        check("pe_wait_bvalid", bvalid, 0);
        check("pe_wait_noc_ready", noc_ready, 1);
        drive_flit(37'h08_CAFE_F00D);
        check("pe_rvalid", rvalid, 1);
        check("pe_rdata", rdata, 32'hCAFE_F00D);
        check("pe_err_hold", err_proto, EXP_ERR);
        next_cycle();

        // Reset while waiting for payload
        drive_flit(37'h10_0000_0006);
        ARESET = 1'b1;
        next_cycle();
        ARESET = 1'b0;
        check_all_zero("rst_wait");

        // Reset while holding a read response
        rready = 1'b0;
        drive_flit(37'h10_0000_0006);
        drive_flit(37'h08_AAAA_5555);
        check("rst_sendr_rvalid_before", rvalid, 1);
        ARESET = 1'b1;
        next_cycle();
        ARESET = 1'b0;
        check_all_zero("rst_sendr");
        rready = 1'b1;

        // Write after reset completes normally
        bready = 1'b1;
        sb_q.push_back('{1'b1, 2'b01, 32'h0});
        drive_flit(37'h10_0000_0003);
        check("post_rst_bvalid", bvalid, 1);
        check("post_rst_bresp", bresp, 2'b01);
        next_cycle();
        check("post_rst_done", bvalid, 0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge ACLK);
        end
        check("sb_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mna_resp_axi_driver.md
MNA_RESP_AXI_DRIVER -- requirements
Module: mna_resp_axi_driver

Interface
REQ-001 Parameter FLIT_W, 37, NoC flit width; bits [36:35] are the flit type.
REQ-002 Parameter DATA_W, 32, AXI4-Lite data width; payload is flit bits [DATA_W-1:0].
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 ACLK  in  1  sole clock; all state changes on rising edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 noc_data  in  37  response flit from the NoC.
REQ-007 noc_valid  in  1  noc_data is valid this cycle.
REQ-008 noc_ready  out  1  block accepts the flit this cycle.
REQ-009 bvalid  out  1 / bready  in  1 / bresp  out  2  AXI4-Lite write-response channel.
REQ-010 rvalid  out  1 / rready  in  1 / rdata  out  32 / rresp  out  2  AXI4-Lite read-data channel.
REQ-011 err_proto  out  1  sticky protocol-error flag.

Function
REQ-012 Flit types SHALL be: 2'b10 header (bit0 = write flag, bits[2:1] = resp code), 2'b01 payload (data [31:0]), 2'b00 idle, 2'b11 reserved.
REQ-013 A flit SHALL be accepted only in a cycle where noc_valid && noc_ready.
REQ-014 FSM states SHALL be IDLE, WAIT_DATA, SEND_B, SEND_R.
REQ-015 noc_ready SHALL be 1 in IDLE and WAIT_DATA and 0 in SEND_B and SEND_R.
REQ-016 IDLE, accepted header with write=1: capture bresp <= [2:1]; next state SEND_B.
REQ-017 IDLE, accepted header with write=0: capture rresp <= [2:1]; next state WAIT_DATA.
REQ-018 WAIT_DATA, accepted payload: capture rdata <= [31:0]; next state SEND_R.
REQ-019 bvalid SHALL equal (state == SEND_B), and rvalid SHALL equal (state == SEND_R), both registered, so each asserts exactly one cycle after the last required flit is accepted.
REQ-020 SEND_B with bready=1 -> IDLE; SEND_R with rready=1 -> IDLE; otherwise hold state and hold bresp/rresp/rdata stable.
REQ-021 A response completes in one cycle when ready is already high; ready asserted before valid SHALL NOT cause a handshake.
REQ-022 Idle-type flits SHALL be accepted and ignored in every state where noc_ready=1.
REQ-023 Unexpected flits SHALL be accepted and dropped with no state change: a payload in IDLE, a header in WAIT_DATA, and a reserved type in any state.
REQ-024 At most one outstanding response is held; there is no queueing beyond one entry.

Reset
REQ-025 With ARESET=1 at a clock edge, state SHALL go to IDLE, and bvalid, rvalid, bresp, rresp, rdata and err_proto SHALL all go to 0.
REQ-026 Reset mid-transaction (WAIT_DATA, SEND_B or SEND_R) SHALL discard the pending response; no valid is asserted on the cycle after reset.
REQ-027 noc_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-028 Macro MNA_RESP_ERR_CHECK_EN: when defined, any flit dropped under REQ-023 SHALL set err_proto to 1, and it stays 1 until reset.
REQ-029 When MNA_RESP_ERR_CHECK_EN is undefined, err_proto SHALL be tied to 0, and dropping behaviour SHALL otherwise be identical.

Structure
REQ-030 Package mna_resp_pkg SHALL hold FLIT_W, DATA_W, the flit-type constants (HDR, PAYLOAD, IDLE, RSVD), the header bit positions and the FSM state encoding.
REQ-031 The block is a single module with flit-field decode inline; no sub-module.

Verification
REQ-032 Write response: header 37'h10_0000_0001 with bready=1 -> bvalid high exactly one cycle later with bresp=00, then back to IDLE; noc_ready=0 during SEND_B.
REQ-033 Read response: header 37'h10_0000_0004, then payload 37'h08_DEAD_BEEF, with rready=1 -> rvalid one cycle after the payload, rdata=32'hDEADBEEF, rresp=10.
REQ-034 Backpressure: bready held 0 for 5 cycles -> bvalid and bresp stable, noc_ready=0 throughout; a handshake occurs on the cycle bready rises.
REQ-035 Protocol error: payload in IDLE, then header in WAIT_DATA -> both dropped, state unchanged; err_proto=1 with the macro and 0 without it.
REQ-036 Reset in WAIT_DATA and in SEND_R -> all outputs 0 the next cycle, noc_ready=1, and a following write response completes normally.
